// File: rtl/key_debounce_ctrl.sv
// Push-button conditioner: per key, a two-flop synchroniser, a debounce FSM with a
// stable-time counter, and registered level / press / release / toggle outputs.
module key_debounce_ctrl #(
   parameter int EXT_CLOCK_FREQ = 50000000,
   parameter int DEBOUNCE_US    = 10000,
   parameter int NUM_KEYS       = 2
) (
   input  logic                EXTCLK,
   input  logic                RST_N,
   input  logic [NUM_KEYS-1:0] KEY_IN,
   output logic [NUM_KEYS-1:0] KEY_LEVEL,
   output logic [NUM_KEYS-1:0] KEY_PRESS,
   output logic [NUM_KEYS-1:0] KEY_RELEASE,
   output logic [NUM_KEYS-1:0] KEY_TOGGLE
);

   localparam int DEBOUNCE_CYCLES = (EXT_CLOCK_FREQ / 1000000) * DEBOUNCE_US;
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         logic             s1_reg;
         logic             s2_reg;
         state_t           state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             level_reg;
         logic             press_reg;
         logic             release_reg;
         logic             toggle_reg;

         always_ff @(posedge EXTCLK or negedge RST_N) begin
            if (!RST_N) begin
               s1_reg      <= 1'b1;
               s2_reg      <= 1'b1;
               state_reg   <= RELEASED;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               toggle_reg  <= 1'b0;
            end else begin
               s1_reg      <= KEY_IN[gi];
               s2_reg      <= s1_reg;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               // Any sample disagreeing with the armed direction drops back and
               // the next arm restarts the count from zero.
               case (state_reg)
                  RELEASED: begin
                     if (!s2_reg) begin
                        state_reg <= ARM_PRESS;
                        cnt_reg   <= '0;
                     end
                  end
                  ARM_PRESS: begin
                     if (s2_reg) begin
                        state_reg <= RELEASED;
                     end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= PRESSED;
                        level_reg  <= 1'b1;
                        press_reg  <= 1'b1;
                        toggle_reg <= ~toggle_reg;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  PRESSED: begin
                     if (s2_reg) begin
                        state_reg <= ARM_RELEASE;
                        cnt_reg   <= '0;
                     end
                  end
                  ARM_RELEASE: begin
                     if (!s2_reg) begin
                        state_reg <= PRESSED;
                     end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= RELEASED;
                        level_reg   <= 1'b0;
                        release_reg <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  default: state_reg <= RELEASED;
               endcase
            end
         end

         assign KEY_LEVEL[gi]   = level_reg;
         assign KEY_PRESS[gi]   = press_reg;
         assign KEY_RELEASE[gi] = release_reg;
         assign KEY_TOGGLE[gi]  = toggle_reg;
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Bench for key_debounce_ctrl with D=8: vector table, hand-written corner sequences,
// and random key activity checked against a run-length reference model.
module tb_key_debounce_ctrl;

   localparam int D = 8;

   logic       EXTCLK;
   logic       RST_N;
   logic [1:0] KEY_IN;
   logic [1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   key_debounce_ctrl #(
      .EXT_CLOCK_FREQ(1000000),
      .DEBOUNCE_US   (8),
      .NUM_KEYS      (2)
   ) dut (
      .EXTCLK     (EXTCLK),
      .RST_N      (RST_N),
      .KEY_IN     (KEY_IN),
      .KEY_LEVEL  (KEY_LEVEL),
      .KEY_PRESS  (KEY_PRESS),
      .KEY_RELEASE(KEY_RELEASE),
      .KEY_TOGGLE (KEY_TOGGLE)
   );

   initial EXTCLK = 1'b0;
   always #5 EXTCLK = ~EXTCLK;

   // Reference: a key's debounced level flips once D+1 consecutive synchronised
   // samples disagree with it; the synchronised sample lags KEY_IN by two edges.
   logic [1:0] m_pipe0, m_pipe1;
   int         m_run [2];
   logic [1:0] m_level, m_toggle, m_press, m_rel;

   // Per-segment pulse accounting
   int         press_cycles, rel_cycles;
   logic [1:0] press_or, rel_or;

   task automatic model_reset();
      m_pipe0  = 2'b11;
      m_pipe1  = 2'b11;
      m_run[0] = 0;
      m_run[1] = 0;
      m_level  = '0;
      m_toggle = '0;
      m_press  = '0;
      m_rel    = '0;
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         m_press[k] = 1'b0;
         m_rel[k]   = 1'b0;
         if ((~m_pipe1[k]) != m_level[k]) begin
            m_run[k]++;
            if (m_run[k] == D + 1) begin
               m_level[k] = ~m_level[k];
               if (m_level[k]) begin
                  m_press[k]  = 1'b1;
                  m_toggle[k] = ~m_toggle[k];
               end else begin
                  m_rel[k] = 1'b1;
               end
               m_run[k] = 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = KEY_IN;
   endtask

   task automatic clear_acc();
      press_cycles = 0;
      rel_cycles   = 0;
      press_or     = '0;
      rel_or       = '0;
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge EXTCLK);
      cyc++;
      if (!RST_N) model_reset();
      else model_step();
      #1;
      checks++;
      if ({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE} !== {m_level, m_press, m_rel, m_toggle}) begin
         errors++;
         $display("FAIL model cyc=%0d got lvl=%b prs=%b rel=%b tog=%b expected lvl=%b prs=%b rel=%b tog=%b",
                  cyc, KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE, m_level, m_press, m_rel, m_toggle);
      end
      if (KEY_PRESS != 2'b00) begin
         press_cycles++;
         press_or |= KEY_PRESS;
      end
      if (KEY_RELEASE != 2'b00) begin
         rel_cycles++;
         rel_or |= KEY_RELEASE;
      end
   endtask

   typedef struct {
      logic [1:0] key_in;
      int         hold;
      logic [1:0] lvl;
      logic [1:0] tog;
      logic [1:0] por;
      int         pc;
      logic [1:0] ror;
      int         rc;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int lat;
      int seg_left [2];
      logic [1:0] bounce_val [4];
      int         bounce_len [4];

      tbl[0] = '{2'b01, 11, 2'b10, 2'b10, 2'b10, 1, 2'b00, 0};
      tbl[1] = '{2'b01,  5, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0};
      tbl[2] = '{2'b11, 10, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0};
      tbl[3] = '{2'b11,  1, 2'b00, 2'b10, 2'b00, 0, 2'b10, 1};
      tbl[4] = '{2'b11,  4, 2'b00, 2'b10, 2'b00, 0, 2'b00, 0};
      tbl[5] = '{2'b01, 11, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0};
      tbl[6] = '{2'b11, 11, 2'b00, 2'b00, 2'b00, 0, 2'b10, 1};
      tbl[7] = '{2'b00, 11, 2'b11, 2'b11, 2'b11, 1, 2'b00, 0};
      tbl[8] = '{2'b11, 11, 2'b00, 2'b11, 2'b00, 0, 2'b11, 1};

      // Reset and idle
      RST_N  = 1'b0;
      KEY_IN = 2'b11;
      model_reset();
      clear_acc();
      repeat (5) tick();
      check("reset_outputs", int'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE}), 0);
      RST_N = 1'b1;
      repeat (20) tick();
      check("idle_outputs", int'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE}), 0);
      check("idle_pulses", press_cycles + rel_cycles, 0);

      // Vector table: clean presses, releases, re-press, simultaneous keys
      for (int i = 0; i < 9; i++) begin
         clear_acc();
         KEY_IN = tbl[i].key_in;
         repeat (tbl[i].hold) tick();
         check($sformatf("tbl%0d_level", i), int'(KEY_LEVEL), int'(tbl[i].lvl));
         check($sformatf("tbl%0d_toggle", i), int'(KEY_TOGGLE), int'(tbl[i].tog));
         check($sformatf("tbl%0d_press_or", i), int'(press_or), int'(tbl[i].por));
         check($sformatf("tbl%0d_press_cycles", i), press_cycles, tbl[i].pc);
         check($sformatf("tbl%0d_release_or", i), int'(rel_or), int'(tbl[i].ror));
         check($sformatf("tbl%0d_release_cycles", i), rel_cycles, tbl[i].rc);
         $display("vector %0d: key_in=%b hold=%0d level=%b toggle=%b press_cycles=%0d release_cycles=%0d",
                  i, tbl[i].key_in, tbl[i].hold, KEY_LEVEL, KEY_TOGGLE, press_cycles, rel_cycles);
      end

      // Bounce on key 1: short low runs must not register
      bounce_val[0] = 2'b01; bounce_len[0] = 5;
      bounce_val[1] = 2'b11; bounce_len[1] = 2;
      bounce_val[2] = 2'b01; bounce_len[2] = 5;
      bounce_val[3] = 2'b11; bounce_len[3] = 3;
      clear_acc();
      for (int i = 0; i < 4; i++) begin
         KEY_IN = bounce_val[i];
         repeat (bounce_len[i]) tick();
      end
      repeat (4) tick();
      check("bounce_press_cycles", press_cycles, 0);
      check("bounce_level", int'(KEY_LEVEL), 0);
      KEY_IN = 2'b01;
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (KEY_PRESS[1]) begin
            lat = n;
            break;
         end
      end
      check("press_latency", lat, D + 3);
      $display("bounce sequence: press latency %0d edges", lat);
      KEY_IN = 2'b11;
      repeat (15) tick();

      // Async reset while key 0 is mid-debounce and key 1 is held
      KEY_IN = 2'b01;
      repeat (12) tick();
      KEY_IN = 2'b00;
      repeat (8) tick();
      #2;
      RST_N  = 1'b0;
      KEY_IN = 2'b11;
      model_reset();
      #1;
      check("async_reset_outputs", int'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE}), 0);
      repeat (3) tick();
      RST_N = 1'b1;
      clear_acc();
      repeat (40) tick();
      check("post_reset_press_cycles", press_cycles, 0);
      check("post_reset_release_cycles", rel_cycles, 0);
      $display("reset mid-debounce: press_cycles=%0d after deassertion", press_cycles);

      // Random key activity with a mix of short bounces and long holds
      seg_left[0] = 0;
      seg_left[1] = 0;
      clear_acc();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (seg_left[k] == 0) begin
               KEY_IN[k]   = 1'($urandom_range(0, 1));
               seg_left[k] = $urandom_range(1, 20);
            end
            seg_left[k]--;
         end
         tick();
      end
      $display("random phase: press_cycles=%0d release_cycles=%0d", press_cycles, rel_cycles);
      check("random_activity_seen", int'(press_cycles > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_ctrl.md
Name: key_debounce_ctrl

Overview:
Conditions the raw active-low push-button inputs of the DE0-Nano before they reach the LED counter stage. Per key, it does three things:
- synchronises the raw input to EXTCLK;
- debounces it with a per-key state machine and counter;
- emits a clean level, single-cycle press/release pulses, and a press-toggled run flag.

The counter stage's count enable is driven from KEY_TOGGLE[1] (or KEY_LEVEL[1]) instead of the raw KEY[1].

Parameters:
EXT_CLOCK_FREQ, 50000000, EXTCLK frequency in Hz
DEBOUNCE_US, 10000, required stable time in microseconds
NUM_KEYS, 2, number of independent key channels
(derived) DEBOUNCE_CYCLES = (EXT_CLOCK_FREQ/1000000)*DEBOUNCE_US, must be >= 2; CNT_W = $clog2(DEBOUNCE_CYCLES)

Ports:
EXTCLK  in  1  system clock, 50 MHz
RST_N  in  1  asynchronous active-low reset; driven from KEY[0] at top level
KEY_IN  in  NUM_KEYS  raw asynchronous buttons, active-low (0 = pressed)
KEY_LEVEL  out  NUM_KEYS  debounced state, active-high (1 = pressed)
KEY_PRESS  out  NUM_KEYS  one-cycle pulse on debounced press
KEY_RELEASE  out  NUM_KEYS  one-cycle pulse on debounced release
KEY_TOGGLE  out  NUM_KEYS  flips on every debounced press

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately):
  - both synchroniser flops preset to 1 (released);
  - FSM = RELEASED, counter = 0;
  - KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_TOGGLE = 0.
- Synchroniser: 2 flops per key (s1, s2). The FSM uses only s2.
- Per-key FSM, with D = DEBOUNCE_CYCLES:
  - RELEASED: if s2=0 -> ARM_PRESS, cnt<=0.
  - ARM_PRESS:
    - if s2=1 -> RELEASED (bounce rejected, no output change);
    - else if cnt==D-1 -> PRESSED, KEY_LEVEL<=1, KEY_PRESS<=1, KEY_TOGGLE<=~KEY_TOGGLE;
    - else cnt<=cnt+1.
  - PRESSED: if s2=1 -> ARM_RELEASE, cnt<=0.
  - ARM_RELEASE:
    - if s2=0 -> PRESSED (bounce rejected);
    - else if cnt==D-1 -> RELEASED, KEY_LEVEL<=0, KEY_RELEASE<=1;
    - else cnt<=cnt+1.
- Outputs:
  - all outputs are registered;
  - KEY_PRESS and KEY_RELEASE default to 0 every cycle, so they are high for exactly one cycle;
  - KEY_TOGGLE is unaffected by release.
- Latency: take the first rising edge at which KEY_IN is sampled low as edge 1. KEY_PRESS and KEY_LEVEL become 1 after edge D+3, provided KEY_IN stays low throughout. Release latency is identical.
- Glitch rejection: any low (or high) excursion shorter than D consecutive s2 samples produces no pulse. The counter restarts from 0 on every bounce.
- Counter: CNT_W bits, never exceeds D-1, no wrap. It is held (don't-care) in RELEASED and PRESSED.
- Channels are fully independent. Simultaneous events on several keys pulse in the same cycle.
- Keys held low through reset: after RST_N rises, the press is detected normally, D+3 edges later.
- Reset mid-debounce: the pending event is discarded. No pulse is emitted after deassertion unless a full new stable period is observed.

Test Plan:
All scenarios use EXT_CLOCK_FREQ=1000000 and DEBOUNCE_US=8, giving D=8.
1. Reset with KEY_IN=2'b11: hold RST_N=0 for 5 cycles -> all outputs 0; release, idle 20 cycles -> outputs remain 0.
2. Clean press: KEY_IN[1]=0, first sampled at edge 1, held -> KEY_PRESS[1]=1 for exactly one cycle after edge 11; KEY_LEVEL[1]=1 and KEY_TOGGLE[1]=1 from edge 11; channel 0 stays 0.
3. Bounce: KEY_IN[1] low 5 cycles, high 2, low 5, high 3 -> no KEY_PRESS and KEY_LEVEL[1]=0 throughout; then hold low -> pulse 11 edges after the final falling sample.
4. Release and re-press: after scenario 2, KEY_IN[1]=1 held -> KEY_RELEASE[1] one cycle after edge 11, KEY_LEVEL[1]=0, KEY_TOGGLE[1] stays 1; a second clean press -> KEY_TOGGLE[1]=0, KEY_PRESS[1] one cycle.
5. Simultaneous: KEY_IN from 2'b11 to 2'b00 on the same edge -> KEY_PRESS=2'b11 in the same single cycle; KEY_LEVEL=2'b11.
6. Reset mid-operation: press KEY_IN[0], assert RST_N=0 while cnt=5 (ARM_PRESS), KEY_IN back to 1 -> outputs 0 immediately (asynchronous, before the next edge); after deassertion, no KEY_PRESS ever appears.
